// File: rtl/program_loader_pkg.sv
// Shared CPU-side constants for the program loader: widths, program limits and FSM encoding.
package program_loader_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned MAX_PROG_LEN = 32;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned STATE_W      = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // A program length is legal when it is 1..MAX_PROG_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_PROG_LEN));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host-to-loader byte stream: valid/data from the host, ready back from the loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);

endinterface

// File: rtl/loader_fifo.sv
// Small power-of-two byte FIFO with synchronous push/pop/flush and an occupancy count.
module loader_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata_c,
  output logic                         full_c,
  output logic                         empty_c,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Flush wins over push/pop; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_pop   = pop && !empty_c;
    do_push  = push && (!full_c || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/program_loader.sv
// Streams a host program of 1..32 bytes through a small FIFO into the CPU Load/data_in pins.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              abort,
  program_loader_if.slave   host,
  output logic              Load,
  output logic [DATA_W-1:0] data_out,
  output logic              run,
  output logic              busy,
  output logic              err,
  output logic [LEN_W-1:0]  word_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_count_q, word_count_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               load_q, load_d;
  logic               run_q, run_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               host_ready_q, host_ready_d;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full_c, fifo_empty_c;
  logic [DATA_W-1:0]  fifo_rdata_c;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   occ_d;

  loader_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (host.host_data),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    load_d       = 1'b0;
    err_d        = 1'b0;
    fifo_flush   = 1'b0;
    fifo_pop     = 1'b0;
    fifo_push    = host.host_valid && host_ready_q && !fifo_full_c;

    if (abort) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (len_legal(prog_len)) begin
              len_d        = prog_len;
              word_count_d = '0;
              acc_d        = '0;
              fifo_flush   = 1'b1;
              state_d      = ST_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          err_d = start;
          if (fifo_push) acc_d = acc_q + LEN_W'(1);
          // Pop only from the registered FIFO head, so a byte needs one edge to land first.
          if (!fifo_empty_c && (word_count_q < len_q)) begin
            fifo_pop     = 1'b1;
            load_d       = 1'b1;
            data_out_d   = fifo_rdata_c;
            word_count_d = word_count_q + LEN_W'(1);
            if (word_count_d == len_q) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    occ_d        = fifo_flush ? '0 : (fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop));
    host_ready_d = (state_d == ST_LOAD) && (occ_d < CNT_W'(DEPTH)) && (acc_d < len_d);
    busy_d       = (state_d == ST_LOAD);
    // run rises one cycle after DONE is entered so it never overlaps the final Load.
    run_d        = (state_d == ST_DONE) && (state_q == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      load_q       <= 1'b0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      host_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      load_q       <= load_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      host_ready_q <= host_ready_d;
    end
  end

  assign host.host_ready = host_ready_q;
  assign Load            = load_q;
  assign data_out        = data_out_q;
  assign run             = run_q;
  assign busy            = busy_q;
  assign err             = err_q;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; inputs driven and outputs sampled on the falling edge.
module tb_program_loader;
  import program_loader_pkg::*;

  logic              clock;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  prog_len;
  logic              abort;
  logic              Load;
  logic [DATA_W-1:0] data_out;
  logic              run;
  logic              busy;
  logic              err;
  logic [LEN_W-1:0]  word_count;

  program_loader_if hif ();

  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .abort      (abort),
    .host       (hif),
    .Load       (Load),
    .data_out   (data_out),
    .run        (run),
    .busy       (busy),
    .err        (err),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load-cycle log and run exclusivity monitor.
  int unsigned tb_cyc = 0;
  logic [7:0]  load_data [$];
  int unsigned load_cyc [$];
  int          excl_viol = 0;

  always @(posedge clock) tb_cyc <= tb_cyc + 1;

  always @(negedge clock) begin
    if (reset && Load) begin
      load_data.push_back(data_out);
      load_cyc.push_back(tb_cyc);
    end
    if (run && (Load || hif.host_ready)) excl_viol++;
  end

  // Feed len bytes base, base+1, ... with an optional idle gap after gap_at bytes; ends when run rises.
  task automatic run_load(input int len, input logic [7:0] base, input int gap_at, input int gap_len,
                          output int ready_drops, output int busy_holes);
    int   sent = 0;
    int   idle = 0;
    int   cyc  = 0;
    logic acc;
    ready_drops = 0;
    busy_holes  = 0;
    while (!run && cyc < 300) begin
      if (sent == gap_at && idle < gap_len) begin
        hif.host_valid = 1'b0;
        idle++;
      end else begin
        hif.host_valid = (sent < len);
        hif.host_data  = base + 8'(sent);
      end
      if (hif.host_valid && !hif.host_ready) ready_drops++;
      if (!Load && !busy) busy_holes++;
      acc = hif.host_valid && hif.host_ready;
      @(negedge clock);
      cyc++;
      if (acc) sent++;
    end
    hif.host_valid = 1'b0;
    check("load_completes", 32'(run), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int rd;
    int bh;
    int max_gap;
    int stray;

    reset = 1'b0; start = 1'b0; prog_len = '0; abort = 1'b0;
    hif.host_valid = 1'b0; hif.host_data = '0;
    #3;
    check("rst_load",  32'(Load), 0);
    check("rst_dout",  32'(data_out), 0);
    check("rst_ready", 32'(hif.host_ready), 0);
    check("rst_run",   32'(run), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_err",   32'(err), 0);
    check("rst_wc",    32'(word_count), 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(hif.host_ready), 0);

    // Illegal lengths from IDLE.
    start = 1'b1; prog_len = 6'd0;
    @(negedge clock);
    check("err_len0", 32'(err), 1);
    prog_len = 6'd33;
    @(negedge clock);
    check("err_len33", 32'(err), 1);
    check("len33_busy", 32'(busy), 0);
    start = 1'b0;
    @(negedge clock);
    check("err_one_cycle", 32'(err), 0);
    check("illegal_idle_busy", 32'(busy), 0);
    check("illegal_idle_run", 32'(run), 0);

    // Three-byte program streamed back to back.
    start = 1'b1; prog_len = 6'd3;
    @(negedge clock);
    start = 1'b0;
    check("l3_busy", 32'(busy), 1);
    check("l3_ready", 32'(hif.host_ready), 1);
    check("l3_wc0", 32'(word_count), 0);
    hif.host_valid = 1'b1; hif.host_data = 8'hA1;
    @(negedge clock);
    check("l3_no_bypass", 32'(Load), 0);
    hif.host_data = 8'hB2;
    @(negedge clock);
    check("l3_load1", 32'(Load), 1);
    check("l3_data1", 32'(data_out), 32'h A1);
    hif.host_data = 8'hC3;
    @(negedge clock);
    check("l3_load2", 32'(Load), 1);
    check("l3_data2", 32'(data_out), 32'h B2);
    check("l3_ready_off", 32'(hif.host_ready), 0);
    hif.host_valid = 1'b0;
    @(negedge clock);
    check("l3_load3", 32'(Load), 1);
    check("l3_data3", 32'(data_out), 32'h C3);
    check("l3_run_late", 32'(run), 0);
    @(negedge clock);
    check("l3_load_end", 32'(Load), 0);
    check("l3_run", 32'(run), 1);
    check("l3_wc", 32'(word_count), 3);
    check("l3_dout_hold", 32'(data_out), 32'h C3);

    // Illegal start while DONE keeps run and word_count.
    start = 1'b1; prog_len = 6'd0;
    @(negedge clock);
    start = 1'b0;
    check("done_err", 32'(err), 1);
    check("done_run_kept", 32'(run), 1);
    check("done_wc_kept", 32'(word_count), 3);

    // Full 32-byte program with host_valid held high.
    idx = load_data.size();
    start = 1'b1; prog_len = 6'd32;
    @(negedge clock);
    start = 1'b0;
    run_load(32, 8'h40, -1, 0, rd, bh);
    check("l32_ready_drops", 32'(rd), 0);
    check("l32_count", 32'(load_data.size() - idx), 32);
    if (load_data.size() - idx == 32) begin
      for (int i = 0; i < 32; i++) check("l32_data", 32'(load_data[idx+i]), 32'(8'h40 + i));
    end
    check("l32_wc", 32'(word_count), 32);
    check("l32_ready_after", 32'(hif.host_ready), 0);

    // Host starvation mid-load.
    idx = load_data.size();
    start = 1'b1; prog_len = 6'd4;
    @(negedge clock);
    start = 1'b0;
    run_load(4, 8'h10, 2, 5, rd, bh);
    check("gap_count", 32'(load_data.size() - idx), 4);
    check("gap_busy_holes", 32'(bh), 0);
    max_gap = 0;
    for (int i = idx; i + 1 < load_cyc.size(); i++) begin
      if (int'(load_cyc[i+1] - load_cyc[i]) - 1 > max_gap) max_gap = int'(load_cyc[i+1] - load_cyc[i]) - 1;
    end
    check("gap_len", 32'(max_gap), 5);
    if (load_data.size() - idx == 4) check("gap_last_data", 32'(load_data[idx+3]), 32'h13);

    // Start during LOAD is ignored; abort after two words.
    start = 1'b1; prog_len = 6'd5;
    @(negedge clock);
    start = 1'b0;
    hif.host_valid = 1'b1; hif.host_data = 8'h50;
    @(negedge clock);
    hif.host_data = 8'h51;
    start = 1'b1; prog_len = 6'd3;
    @(negedge clock);
    start = 1'b0;
    check("load_start_err", 32'(err), 1);
    check("load_start_busy", 32'(busy), 1);
    hif.host_data = 8'h52;
    @(negedge clock);
    check("ab_load2", 32'(Load), 1);
    check("ab_data2", 32'(data_out), 32'h51);
    check("ab_wc2", 32'(word_count), 2);
    abort = 1'b1; hif.host_valid = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    check("ab_load", 32'(Load), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_run", 32'(run), 0);
    check("ab_ready", 32'(hif.host_ready), 0);
    check("ab_fifo_empty", 32'(dut.u_fifo.empty_c), 1);
    idx = load_data.size();
    start = 1'b1; prog_len = 6'd1;
    @(negedge clock);
    start = 1'b0;
    run_load(1, 8'h7E, -1, 0, rd, bh);
    check("ab_one_count", 32'(load_data.size() - idx), 1);
    if (load_data.size() - idx == 1) check("ab_one_data", 32'(load_data[idx]), 32'h7E);
    check("ab_one_wc", 32'(word_count), 1);

    // Reset mid-load with bytes in flight.
    start = 1'b1; prog_len = 6'd8;
    @(negedge clock);
    start = 1'b0;
    hif.host_valid = 1'b1; hif.host_data = 8'h90;
    @(negedge clock); hif.host_data = 8'h91;
    @(negedge clock); hif.host_data = 8'h92;
    @(negedge clock);
    check("mr_loading", 32'(Load), 1);
    #2 reset = 1'b0;
    #1;
    check("mr_load", 32'(Load), 0);
    check("mr_dout", 32'(data_out), 0);
    check("mr_ready", 32'(hif.host_ready), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_run", 32'(run), 0);
    check("mr_wc", 32'(word_count), 0);
    check("mr_fifo_empty", 32'(dut.u_fifo.empty_c), 1);
    @(negedge clock);
    reset = 1'b1;
    idx = load_data.size();
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (Load || hif.host_ready || busy) stray++;
    end
    hif.host_valid = 1'b0;
    check("mr_no_activity", 32'(stray), 0);
    check("mr_no_loads", 32'(load_data.size() - idx), 0);

    check("run_exclusive", 32'(excl_viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
